// File: rtl/coin_pkg.sv
// Shared definitions for the coin front end: FSM states, channel indices and
// denomination values used by the machine and benches.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int NUM_CH = 3;
  localparam int CH_N   = 0;
  localparam int CH_D   = 1;
  localparam int CH_Q   = 2;

  localparam int VAL_N  = 5;
  localparam int VAL_D  = 10;
  localparam int VAL_Q  = 25;

  localparam logic [1:0] PEND_MAX = 2'd3;

  // Width for a counter that must hold 0..maxVal, never narrower than 1 bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchroniser, debounce counter and a registered
// single-cycle pulse on each accepted 0->1 change of the stable level.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin front end: debounced sensors feed saturating per-channel queues drained
// Q > D > N as spaced one-hot pulses. Optional jam detection under JAM_DETECT_EN.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_n_raw,
  input  logic coin_d_raw,
  input  logic coin_q_raw,
  output logic N,
  output logic D,
  output logic Q,
  output logic busy,
  output logic ovf,
  output logic jam
);

  localparam int GW = cntWidth(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [NUM_CH-1:0]      raw, stable, rise;
  logic [NUM_CH-1:0][1:0] pend_q, pend_d;
  logic [NUM_CH-1:0]      emit_q, emit_d;
  logic [GW-1:0]          gap_q, gap_d;
  state_e                 state_q, state_d;
  logic [1:0]             sel;
  logic                   anyPend, take, jamBlock;
  logic                   ovf_q, ovf_d;

  assign raw[CH_N] = coin_n_raw;
  assign raw[CH_D] = coin_d_raw;
  assign raw[CH_Q] = coin_q_raw;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDeb (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (raw[ch]),
      .stable_o (stable[ch]),
      .rise_o   (rise[ch])
    );
  end

  always_comb begin
    anyPend = (pend_q[CH_Q] != 2'd0) || (pend_q[CH_D] != 2'd0) || (pend_q[CH_N] != 2'd0);
    sel     = 2'(CH_N);
    if (pend_q[CH_Q] != 2'd0)      sel = 2'(CH_Q);
    else if (pend_q[CH_D] != 2'd0) sel = 2'(CH_D);
  end

  // Leaving EMIT or the last GAP cycle chains straight into the next EMIT so
  // queued coins are spaced exactly GAP_CYCLES+1 apart.
  always_comb begin
    state_d = state_q;
    gap_d   = '0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (anyPend && !jamBlock) begin
          state_d = EMIT;
          take    = 1'b1;
        end
      end
      EMIT: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
        end else if (anyPend && !jamBlock) begin
          state_d = EMIT;
          take    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end else if (anyPend && !jamBlock) begin
          state_d = EMIT;
          take    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    emit_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      emit_d[ch] = take && (sel == 2'(ch));
    end
  end

  // A simultaneous edge and issue on one channel cancel; saturated edges are dropped.
  always_comb begin
    ovf_d  = ovf_q;
    pend_d = pend_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (jamBlock) begin
        pend_d[ch] = 2'd0;
      end else if (rise[ch] && !emit_d[ch]) begin
        if (pend_q[ch] == PEND_MAX) ovf_d = 1'b1;
        else                        pend_d[ch] = pend_q[ch] + 2'd1;
      end else if (!rise[ch] && emit_d[ch]) begin
        pend_d[ch] = pend_q[ch] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      emit_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      emit_q  <= emit_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef JAM_DETECT_EN
  localparam int JW = cntWidth(JAM_CYCLES);
  localparam logic [JW-1:0] JAM_TERM = JW'(JAM_CYCLES);
  localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);

  logic [NUM_CH-1:0][JW-1:0] jamCnt_q, jamCnt_d;
  logic                      jam_q, jamHit;

  always_comb begin
    jamHit   = 1'b0;
    jamCnt_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (stable[ch]) begin
        jamCnt_d[ch] = (jamCnt_q[ch] != JAM_TERM) ? jamCnt_q[ch] + 1'b1 : jamCnt_q[ch];
        if (jamCnt_q[ch] == JAM_LAST) jamHit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jamCnt_q <= '0;
      jam_q    <= 1'b0;
    end else begin
      jamCnt_q <= jamCnt_d;
      jam_q    <= jam_q | jamHit;
    end
  end

  assign jamBlock = jam_q | jamHit;
  assign jam      = jam_q;
`else
  logic unusedJamInputs;
  assign unusedJamInputs = ^{stable, JAM_CYCLES[0]};
  assign jamBlock        = 1'b0;
  assign jam             = 1'b0;
`endif

  assign N    = emit_q[CH_N];
  assign D    = emit_q[CH_D];
  assign Q    = emit_q[CH_Q];
  assign ovf  = ovf_q;
  assign busy = (state_q != IDLE) || anyPend;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench for coin_input_conditioner; jam expectations follow JAM_DETECT_EN.
module tb_coin_input_conditioner;
  import coin_pkg::*;

  localparam int DB   = 4;
  localparam int GAPC = 2;
  localparam int JAMC = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nRaw = 1'b0, dRaw = 1'b0, qRaw = 1'b0;
  logic N, D, Q, busy, ovf, jam;
  logic n2Raw = 1'b0, zero2 = 1'b0;
  logic N2, D2, Q2, busy2, ovf2, jam2;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GAPC), .JAM_CYCLES(JAMC)) dut (
    .clk(clk), .rst(rst), .coin_n_raw(nRaw), .coin_d_raw(dRaw), .coin_q_raw(qRaw),
    .N(N), .D(D), .Q(Q), .busy(busy), .ovf(ovf), .jam(jam)
  );

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DB), .GAP_CYCLES(50), .JAM_CYCLES(JAMC)) dut2 (
    .clk(clk), .rst(rst), .coin_n_raw(n2Raw), .coin_d_raw(zero2), .coin_q_raw(zero2),
    .N(N2), .D(D2), .Q(Q2), .busy(busy2), .ovf(ovf2), .jam(jam2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int ch;
    int at;
  } exp_t;
  exp_t expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Raise the masked sensors {q,d,n} and queue the pulses they should produce.
  task automatic applyStimulus(input logic [2:0] mask, input bit expectPulses, output int t0);
    int k;
    @(negedge clk);
    t0 = cyc;
    qRaw = mask[2];
    dRaw = mask[1];
    nRaw = mask[0];
    k = 0;
    if (expectPulses) begin
      if (mask[2]) begin expQ.push_back('{CH_Q, t0 + DB + 4 + k * (GAPC + 1)}); k++; end
      if (mask[1]) begin expQ.push_back('{CH_D, t0 + DB + 4 + k * (GAPC + 1)}); k++; end
      if (mask[0]) begin expQ.push_back('{CH_N, t0 + DB + 4 + k * (GAPC + 1)}); k++; end
    end
  endtask

  task automatic releaseAll();
    qRaw = 1'b0;
    dRaw = 1'b0;
    nRaw = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic coin2();
    @(negedge clk);
    n2Raw = 1'b1;
    waitCycles(5);
    n2Raw = 1'b0;
    waitCycles(4);
  endtask

  // Main-DUT monitor: every pulse is matched against the head of the queue.
  always @(negedge clk) begin
    if (!rst && (N || D || Q)) begin
      int got;
      exp_t e;
      got = N ? CH_N : (D ? CH_D : CH_Q);
      checkOutput("onehot", $countones({N, D, Q}), 1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected pulse channel", got, -1);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse channel", got, e.ch);
        checkOutput("pulse cycle", cyc, e.at);
      end
    end
  end

  int n2Count = 0;
  int stray2 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (N2) n2Count++;
      if (D2 || Q2) stray2++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic busyHi;

    waitCycles(3);
    rst = 1'b0;
    checkOutput("reset N", N, 0);
    checkOutput("reset D", D, 0);
    checkOutput("reset Q", Q, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset jam", jam, 0);
    checkOutput("reset busy2", busy2, 0);
    waitCycles(2);

    $display("[TB] quarter held 10 cycles");
    applyStimulus(3'b100, 1'b1, t0);
    waitCycles(10);
    releaseAll();
    waitCycles(30);
    checkOutput("idle after quarter", busy, 0);

    $display("[TB] dime glitch of 3 cycles");
    applyStimulus(3'b010, 1'b0, t0);
    busyHi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) releaseAll();
      @(negedge clk);
      busyHi = busyHi | busy;
    end
    checkOutput("glitch busy", busyHi, 0);

    $display("[TB] simultaneous n/d/q");
    applyStimulus(3'b111, 1'b1, t0);
    waitCycles(10);
    releaseAll();
    waitCycles(40);
    checkOutput("idle after burst", busy, 0);

    $display("[TB] nickel saturation on gap=50 instance");
    for (int i = 0; i < 5; i++) coin2();
    checkOutput("sat pulses before drain", n2Count, 1);
    checkOutput("sat ovf", ovf2, 1);
    waitCycles(200);
    checkOutput("sat pulses after drain", n2Count, 4);
    checkOutput("sat ovf sticky", ovf2, 1);
    checkOutput("sat busy drained", busy2, 0);
    for (int i = 0; i < 5; i++) coin2();
    checkOutput("second burst pulses", n2Count, 5);
    checkOutput("second burst busy", busy2, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post-rst ovf", ovf2, 0);
    checkOutput("post-rst busy", busy2, 0);
    waitCycles(150);
    checkOutput("post-rst no pulse", n2Count, 5);

    $display("[TB] nickel held 40 cycles");
    applyStimulus(3'b001, 1'b1, t0);
    waitCycles(25);
    checkOutput("jam before threshold", jam, 0);
    waitCycles(2);
`ifdef JAM_DETECT_EN
    checkOutput("jam at threshold", jam, 1);
`else
    checkOutput("jam disabled", jam, 0);
`endif
    waitCycles(13);
    releaseAll();
    waitCycles(20);
`ifdef JAM_DETECT_EN
    applyStimulus(3'b010, 1'b0, t0);
`else
    applyStimulus(3'b010, 1'b1, t0);
`endif
    waitCycles(10);
    releaseAll();
    waitCycles(30);
`ifdef JAM_DETECT_EN
    checkOutput("jam sticky", jam, 1);
    checkOutput("jam busy", busy, 0);
`else
    checkOutput("jam stays low", jam, 0);
`endif

    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("dut2 stray D/Q", stray2, 0);
    checkOutput("main ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
